// File: rtl/mem_access_unit.sv
// Load/store master for the 64 KiB byte-addressed data RAM: one access at a time, little-endian,
// zero/sign-extended loads. Define MEM_ALIGN_CHECK_EN to reject misaligned 32/64-bit accesses.
module mem_access_unit #(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_signed_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          mem_load_o,
    output logic [1:0]    mem_wr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_d_o,
    input  logic [DW-1:0] mem_q_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    localparam logic [AW:0] ADDR_MAX = {1'b0, {AW{1'b1}}};

    state_t        state_q, state_d;
    logic          we_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    span_m1;
    logic          accept;

    assign accept = (state_q == S_IDLE) && req_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid_i) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // mem_load is decoded from state alone so an async reset kills a store mid-cycle.
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        mem_load_o  = (state_q == S_ACCESS) && we_q && !err_q;
        rsp_err_o   = (state_q == S_RESP) && err_q;
        rsp_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
        mem_wr_o    = size_q;
        mem_addr_o  = addr_q;
        mem_d_o     = wdata_q;
    end

    always_comb begin
        span_m1 = 4'd0;
        case (req_size_i)
            2'b01:   span_m1 = 4'd0;
            2'b10:   span_m1 = 4'd3;
            2'b11:   span_m1 = 4'd7;
            default: span_m1 = 4'd0;
        endcase
        // Last byte must stay inside the RAM; accesses never wrap to address 0.
        err_d = (req_size_i == 2'b00) ||
                (({1'b0, req_addr_i} + {{(AW-3){1'b0}}, span_m1}) > ADDR_MAX);
`ifdef MEM_ALIGN_CHECK_EN
        if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) err_d = 1'b1;
        if (req_size_i == 2'b11 && req_addr_i[2:0] != 3'b000) err_d = 1'b1;
`else
`endif
    end

    always_comb begin
        rdata_d = '0;
        case (size_q)
            2'b01:   rdata_d = signed_q ? {{(DW-8){mem_q_i[7]}}, mem_q_i[7:0]}
                                        : {{(DW-8){1'b0}}, mem_q_i[7:0]};
            2'b10:   rdata_d = signed_q ? {{(DW-32){mem_q_i[31]}}, mem_q_i[31:0]}
                                        : {{(DW-32){1'b0}}, mem_q_i[31:0]};
            2'b11:   rdata_d = mem_q_i;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else if (accept) begin
            we_q     <= req_we_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            err_q    <= err_d;
            rdata_q  <= '0;
        end else if (state_q == S_ACCESS && !we_q && !err_q) begin
            rdata_q  <= rdata_d;
        end
    end

endmodule
